// File: rtl/order_msg_pkg.sv
// Shared types and constants for the order message parser.
//   state_e     : frame parser states, one per byte position
//   order_txn_t : one decoded order transaction
package order_msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_CID,
    ST_AHI,
    ST_ALO,
    ST_CHK
  } state_e;

  localparam logic [7:0]  TYPE_NEW    = 8'h01;
  localparam logic [7:0]  TYPE_CANCEL = 8'h02;
  localparam int unsigned FRAME_LEN   = 6;

  typedef struct packed {
    logic [4:0]  client_id;
    logic [15:0] amount;
    logic        is_cancel;
  } order_txn_t;

  function automatic logic type_ok(input logic [7:0] t);
    return (t == TYPE_NEW) || (t == TYPE_CANCEL);
  endfunction

endpackage

// File: rtl/order_msg_parser_txn_reg.sv
// One-entry output holding register with valid/ready.
//   clk, rst_n    : clock, synchronous active-low reset
//   load_i        : capture txn_i this cycle (caller guarantees room)
//   txn_i         : transaction to capture
//   out_ready_i   : consumer accepts the held transaction
//   out_valid_o   : a transaction is held
//   txn_o         : held transaction, stable while out_valid_o & !out_ready_i
module order_txn_reg
  import order_msg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  order_txn_t txn_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output order_txn_t txn_o
);

  logic       valid_q;
  order_txn_t txn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      txn_q   <= '0;
    end else if (load_i) begin
      // A load in the same cycle as a transfer replaces the entry.
      valid_q <= 1'b1;
      txn_q   <= txn_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign txn_o       = txn_q;

endmodule

// File: rtl/order_msg_parser.sv
// Byte-serial order message parser.
// Frame: SOF, TYPE, CID, AMT_HI, AMT_LO, CHK (CHK = XOR of TYPE..AMT_LO).
// Good frames are emitted through a one-entry valid/ready register;
// malformed, checksum-failing or timed-out frames are dropped and counted.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_data/in_valid/in_ready  : input byte stream handshake
//   out_valid/out_ready        : output transaction handshake
//   out_client_id/out_amount/out_is_cancel : transaction fields
//   msg_count                  : good messages emitted (wraps)
//   err_count                  : dropped frames (saturates)
module order_msg_parser
  import order_msg_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_client_id,
  output logic [15:0]      out_amount,
  output logic             out_is_cancel,
  output logic [15:0]      msg_count,
  output logic [ERR_W-1:0] err_count
);

  // Timer only needs to hold 0..TIMEOUT_CYC-1; the terminal count is detected
  // on the increment and the timer returns to zero.
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       chk_q;
  logic             is_cancel_q;
  logic [4:0]       cid_q;
  logic [15:0]      amt_q;
  logic [15:0]      msg_q;
  logic [ERR_W-1:0] err_q;

  logic       accept;
  logic       timeout;
  logic       byte_err;
  logic       load;
  order_txn_t txn_d;
  order_txn_t txn_out;

  // Backpressure only at the checksum byte, where a good frame would need
  // the output register.
  assign in_ready = rst_n && !((state_q == ST_CHK) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // Timer advances only on non-transfer cycles with in_ready high.
  assign timeout = (state_q != ST_IDLE) && in_ready && !accept &&
                   (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    byte_err = 1'b0;
    load     = 1'b0;
    if (accept) begin
      case (state_q)
        ST_TYPE: byte_err = !type_ok(in_data);
        ST_CID:  byte_err = (in_data[7:5] != 3'b000);
        ST_CHK: begin
          load     = (in_data == chk_q);
          byte_err = (in_data != chk_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    txn_d.client_id = cid_q;
    txn_d.amount    = amt_q;
    txn_d.is_cancel = is_cancel_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      chk_q       <= '0;
      is_cancel_q <= 1'b0;
      cid_q       <= '0;
      amt_q       <= '0;
      msg_q       <= '0;
      err_q       <= '0;
    end else begin
      if (accept || timeout) begin
        timer_q <= '0;
      end else if ((state_q != ST_IDLE) && in_ready) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      if (timeout) begin
        state_q <= ST_IDLE;
      end else if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (in_data == SOF_BYTE) state_q <= ST_TYPE;
          end
          ST_TYPE: begin
            if (byte_err) begin
              state_q <= ST_IDLE;
            end else begin
              state_q     <= ST_CID;
              chk_q       <= in_data;
              is_cancel_q <= (in_data == TYPE_CANCEL);
            end
          end
          ST_CID: begin
            if (byte_err) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_AHI;
              chk_q   <= chk_q ^ in_data;
              cid_q   <= in_data[4:0];
            end
          end
          ST_AHI: begin
            state_q      <= ST_ALO;
            chk_q        <= chk_q ^ in_data;
            amt_q[15:8]  <= in_data;
          end
          ST_ALO: begin
            state_q     <= ST_CHK;
            chk_q       <= chk_q ^ in_data;
            amt_q[7:0]  <= in_data;
          end
          ST_CHK: begin
            state_q <= ST_IDLE;
            if (load) msg_q <= msg_q + 16'd1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      if ((byte_err || timeout) && (err_q != '1)) begin
        err_q <= err_q + ERR_W'(1);
      end
    end
  end

  order_txn_reg u_txn_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .txn_i       (txn_d),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .txn_o       (txn_out)
  );

  assign out_client_id = txn_out.client_id;
  assign out_amount    = txn_out.amount;
  assign out_is_cancel = txn_out.is_cancel;
  assign msg_count     = msg_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_order_msg_parser.sv
// Scoreboard bench for order_msg_parser: stimulus feeds a byte-level
// reference model that queues expected transactions; a separate monitor
// drives out_ready and checks every output transfer.
module tb_order_msg_parser;
  import order_msg_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_client_id;
  logic [15:0] out_amount;
  logic        out_is_cancel;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  order_msg_parser #(.SOF_BYTE(8'hA5), .TIMEOUT_CYC(TO), .ERR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_client_id (out_client_id),
    .out_amount    (out_amount),
    .out_is_cancel (out_is_cancel),
    .msg_count     (msg_count),
    .err_count     (err_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          or_mode = 0;  // 0 random out_ready, 1 hold low, 2 hold high
  order_txn_t  exp_q[$];
  logic [7:0]  frm_q[$];     // bytes of the frame currently being collected
  logic [15:0] m_msg = 16'd0;
  logic [7:0]  m_err = 8'd0;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    frm_q.delete();
    exp_q.delete();
    m_msg = 16'd0;
    m_err = 8'd0;
  endfunction

  function automatic void model_drop();
    frm_q.delete();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic void model_gap(input int unsigned g);
    if (frm_q.size() != 0 && g >= TO) model_drop();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    order_txn_t t;
    logic [7:0] x;
    if (frm_q.size() == 0) begin
      if (b == 8'hA5) frm_q.push_back(b);
      return;
    end
    frm_q.push_back(b);
    case (frm_q.size())
      2: if (b != 8'h01 && b != 8'h02) model_drop();
      3: if (b > 8'h1F) model_drop();
      6: begin
        x = frm_q[1] ^ frm_q[2] ^ frm_q[3] ^ frm_q[4];
        if (x == b) begin
          t.client_id = frm_q[2][4:0];
          t.amount    = {frm_q[3], frm_q[4]};
          t.is_cancel = (frm_q[1] == 8'h02);
          exp_q.push_back(t);
          m_msg = m_msg + 16'd1;
          frm_q.delete();
        end else begin
          model_drop();
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] x4(input logic [7:0] a, b, c, d);
    return a ^ b ^ c ^ d;
  endfunction

  // ---------------- driver ----------------
  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Entered just after a posedge with in_valid already presenting a byte.
  task automatic wait_accept();
    int unsigned w = 0;
    @(negedge clk);
    while (!in_ready) begin
      w++;
      if (w > 2000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_wait: got 0 expected 1 within 2000 cycles");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input int unsigned gap);
    model_gap(gap);
    if (gap != 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    model_byte(b);
    in_data  = b;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic feed6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    feed(b0, 0); feed(b1, 0); feed(b2, 0);
    feed(b3, 0); feed(b4, 0); feed(b5, 0);
  endtask

  task automatic settle(input string tag);
    or_mode = 2;
    repeat (TO + 6) @(posedge clk);
    #1;
    model_gap(TO + 6);
    expect_eq({tag, "_msg_count"}, 32'(msg_count), 32'(m_msg));
    expect_eq({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    expect_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    or_mode = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    order_txn_t got, held, e;
    logic       held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        got.client_id = out_client_id;
        got.amount    = out_amount;
        got.is_cancel = out_is_cancel;
        if (held_v && out_valid) expect_eq("hold_stable", 32'(got), 32'(held));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            expect_eq("txn", 32'(got), 32'(e));
          end
        end
        held_v = out_valid && !out_ready;
        held   = got;
      end
      @(posedge clk);
      #1;
      case (or_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #900000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  f[6];
    logic [7:0]  typ, cid, c2;
    logic [15:0] amt;
    int unsigned kind, gap, len;

    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_in_ready", 32'(in_ready), 32'd0);
    expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Good new-order frame, then mid-frame reset.
    feed6(8'hA5, 8'h01, 8'h07, 8'h12, 8'h34, x4(8'h01, 8'h07, 8'h12, 8'h34));
    settle("good");
    feed(8'hA5, 0); feed(8'h01, 0); feed(8'h07, 0);
    rst_n = 1'b0;
    @(negedge clk);
    expect_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    expect_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("midrst_cid", 32'(out_client_id), 32'd0);
    expect_eq("midrst_amount", 32'(out_amount), 32'd0);
    expect_eq("midrst_cancel", 32'(out_is_cancel), 32'd0);
    expect_eq("midrst_msg", 32'(msg_count), 32'd0);
    expect_eq("midrst_err", 32'(err_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    feed6(8'hA5, 8'h01, 8'h07, 8'h12, 8'h34, x4(8'h01, 8'h07, 8'h12, 8'h34));
    feed6(8'hA5, 8'h02, 8'h1F, 8'h00, 8'h05, 8'h18);
    settle("cancel");

    // Bad checksum followed by a good frame.
    feed6(8'hA5, 8'h01, 8'h07, 8'h12, 8'h34, 8'h00);
    feed6(8'hA5, 8'h01, 8'h0A, 8'hBE, 8'hEF, x4(8'h01, 8'h0A, 8'hBE, 8'hEF));
    settle("badchk");

    // Bad CID, bad type; trailing bytes are hunted as idle bytes.
    feed6(8'hA5, 8'h01, 8'h20, 8'h12, 8'h34, x4(8'h01, 8'h20, 8'h12, 8'h34));
    feed6(8'hA5, 8'h03, 8'h07, 8'h12, 8'h34, x4(8'h03, 8'h07, 8'h12, 8'h34));
    settle("badfield");

    // Timeout at exactly TO idle cycles; TO-1 is still tolerated.
    feed(8'hA5, 0); feed(8'h01, 0); feed(8'h07, TO);
    feed6(8'hA5, 8'h02, 8'h03, 8'h00, 8'h10, x4(8'h02, 8'h03, 8'h00, 8'h10));
    feed(8'hA5, 0); feed(8'h01, 0); feed(8'h11, 0);
    feed(8'h22, TO - 1); feed(8'h33, 0); feed(x4(8'h01, 8'h11, 8'h22, 8'h33), 0);
    settle("timeout");

    // Backpressure: second CHK byte stalls until out_ready returns.
    or_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    feed6(8'hA5, 8'h01, 8'h05, 8'h0F, 8'hF0, x4(8'h01, 8'h05, 8'h0F, 8'hF0));
    feed(8'hA5, 0); feed(8'h02, 0); feed(8'h06, 0); feed(8'hAA, 0); feed(8'h55, 0);
    c2 = x4(8'h02, 8'h06, 8'hAA, 8'h55);
    model_gap(0);
    model_byte(c2);
    in_data  = c2;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      expect_eq("bp_in_ready", 32'(in_ready), 32'd0);
      expect_eq("bp_hold_cid", 32'(out_client_id), 32'd5);
      expect_eq("bp_hold_amt", 32'(out_amount), 32'h0FF0);
    end
    @(posedge clk);
    #1;
    or_mode = 2;
    wait_accept();
    settle("backpressure");

    // Randomized mix of good, corrupted, junk and stalled frames.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 6);
      typ  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      cid  = 8'($urandom_range(0, 31));
      amt  = 16'($urandom);
      f[0] = 8'hA5; f[1] = typ; f[2] = cid; f[3] = amt[15:8]; f[4] = amt[7:0];
      f[5] = x4(f[1], f[2], f[3], f[4]);
      len  = 6;
      case (kind)
        3: f[5] = f[5] ^ 8'($urandom_range(1, 255));
        4: f[1] = 8'($urandom_range(3, 255));
        5: f[2] = f[2] | (8'h20 << $urandom_range(0, 2));
        6: begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < 6; j++) f[j] = 8'($urandom);
        end
        default: ;
      endcase
      for (int j = 0; j < int'(len); j++) begin
        if (frm_q.size() >= 1 && frm_q.size() <= 4 && $urandom_range(0, 11) == 0) begin
          case ($urandom_range(0, 2))
            0:       gap = TO - 1;
            1:       gap = TO;
            default: gap = TO + 3;
          endcase
        end else begin
          gap = $urandom_range(0, 2);
        end
        feed(f[j], gap);
      end
    end
    settle("random");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      feed(8'hA5, 0);
      feed(8'h03, 0);
    end
    settle("err_sat");

    finish_run();
  end

endmodule
